// File: rtl/eaglesong_pkg.sv
// Shared types and constants for the Eaglesong message loader and its byte packer.
package eaglesong_pkg;

    localparam int DIGEST_W      = 256;
    localparam int LEN_W         = 7;
    localparam int MAX_MSG_BYTES = 32;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic [DIGEST_W-1:0] digest;
        logic [LEN_W-1:0]    length;
        logic                error;
    } result_t;

endpackage

// File: rtl/eaglesong_msg_loader_if.sv
// Byte-stream input, digest-core side and result port of the message loader.
interface eaglesong_msg_loader_if;
    import eaglesong_pkg::*;

    logic [7:0]          s_byte;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic [DIGEST_W-1:0] core_input_val;
    logic [LEN_W-1:0]    core_input_length_bytes;
    logic                core_start_eval;
    logic [DIGEST_W-1:0] core_output_val;
    logic                core_eval_output_ready;
    logic [DIGEST_W-1:0] m_digest;
    logic [LEN_W-1:0]    m_length;
    logic                m_valid;
    logic                m_ready;
    logic                m_error;
    logic                busy;

    // Loader side: consumes bytes and core results, drives the core and the result port.
    modport master (
        input  s_byte, s_valid, s_last, core_output_val, core_eval_output_ready, m_ready,
        output s_ready, core_input_val, core_input_length_bytes, core_start_eval,
               m_digest, m_length, m_valid, m_error, busy
    );

    // Environment side: byte source, digest core and result consumer.
    modport slave (
        output s_byte, s_valid, s_last, core_output_val, core_eval_output_ready, m_ready,
        input  s_ready, core_input_val, core_input_length_bytes, core_start_eval,
               m_digest, m_length, m_valid, m_error, busy
    );

endinterface

// File: rtl/eaglesong_byte_packer.sv
// Packs accepted bytes little-endian into a 256-bit word; counts bytes and flags overflow.
module eaglesong_byte_packer
    import eaglesong_pkg::*;
#(
    parameter int MAX_BYTES = MAX_MSG_BYTES
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                accept,
    input  logic                clear,
    input  logic [7:0]          s_byte,
    output logic [DIGEST_W-1:0] data,
    output logic [LEN_W-1:0]    count,
    output logic                dropping
);

    logic [DIGEST_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]    count_q;
    logic                ovf_q;

    // Once the message is full every further byte is discarded until the end of the message.
    assign dropping = ovf_q || (count_q == LEN_W'(MAX_BYTES));

    always_comb begin
        // NOTE: default assigned first so every path drives data_d and no latch is inferred.
        data_d = data_q;
        if (accept && !dropping) begin
            // The first byte of a message wipes all lanes so no stale byte survives.
            if (count_q == '0) begin
                data_d = '0;
            end
            for (int k = 0; k < MAX_MSG_BYTES; k++) begin
                if (count_q == LEN_W'(k)) begin
                    data_d[8*k +: 8] = s_byte;
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            if (clear) begin
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else if (accept) begin
                if (dropping) begin
                    ovf_q <= 1'b1;
                end else begin
                    count_q <= count_q + LEN_W'(1);
                end
            end
        end
    end

    assign data  = data_q;
    assign count = count_q;

endmodule

// File: rtl/eaglesong_msg_loader.sv
// Feeds a byte-stream message into the Eaglesong digest core and returns the digest on a valid/ready port.
module eaglesong_msg_loader
    import eaglesong_pkg::*;
#(
    parameter int MAX_BYTES          = 32,
    parameter int START_PULSE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES     = 120
) (
    input logic                   clk,
    input logic                   reset_n,
    eaglesong_msg_loader_if.master bus
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > START_PULSE_CYCLES) ? TIMEOUT_CYCLES : START_PULSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [LEN_W-1:0]    len_q, len_d;
    result_t             res_q, res_d;
    logic                accept;
    logic                clear;
    logic                dropping;
    logic [LEN_W-1:0]    count;
    logic [DIGEST_W-1:0] packed_val;

    assign accept = (state_q == LOAD) && bus.s_valid;

    eaglesong_byte_packer #(
        .MAX_BYTES (MAX_BYTES)
    ) u_packer (
        .clk      (clk),
        .reset_n  (reset_n),
        .accept   (accept),
        .clear    (clear),
        .s_byte   (bus.s_byte),
        .data     (packed_val),
        .count    (count),
        .dropping (dropping)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        res_d   = res_q;
        clear   = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (accept && bus.s_last) begin
                    if (dropping) begin
                        // An oversized message never reaches the core.
                        state_d = DONE;
                        res_d   = '{digest: '0, length: LEN_W'(MAX_BYTES), error: 1'b1};
                    end else begin
                        state_d = START;
                        len_d   = count + LEN_W'(1);
                    end
                end
            end
            START: begin
                if (cnt_q == CNT_W'(START_PULSE_CYCLES - 1)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Ready may still be high from the previous result during the first WAIT cycle.
                if ((cnt_q != '0) && bus.core_eval_output_ready) begin
                    state_d = DONE;
                    res_d   = '{digest: bus.core_output_val, length: len_q, error: 1'b0};
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    res_d   = '{digest: '0, length: len_q, error: 1'b1};
                end
            end
            DONE: begin
                if (bus.m_ready) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            len_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            res_q   <= res_d;
            // One counter serves both the start pulse and the result timeout.
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if ((state_q == START) || (state_q == WAIT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.s_ready                 = (state_q == LOAD);
    assign bus.busy                    = (state_q != LOAD);
    assign bus.core_start_eval         = (state_q == START);
    assign bus.core_input_val          = packed_val;
    assign bus.core_input_length_bytes = len_q;
    assign bus.m_valid                 = (state_q == DONE);
    assign bus.m_digest                = res_q.digest;
    assign bus.m_length                = res_q.length;
    assign bus.m_error                 = res_q.error;

endmodule

// File: tb/tb_eaglesong_msg_loader.sv
// Directed bench for eaglesong_msg_loader with a behavioural stand-in for the digest core.
module tb_eaglesong_msg_loader;
    import eaglesong_pkg::*;

    localparam logic [255:0] HELLO_VAL = 256'h0A21646C726F77202C6F6C6C6548;
    localparam logic [255:0] HELLO_DIG =
        256'hD6727D073CE7EC1ECA9F52DBD0E4954B3F4DCB6B0B43C25D6162D141247E8664;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] tx[$];

    // Core stand-in: known digest for the reference message, ~val ^ len otherwise.
    logic         stub_ready  = 1'b0;
    logic [255:0] stub_out    = '0;
    logic         stub_armed  = 1'b0;
    int           stub_cd     = 0;
    logic         core_dead   = 1'b0;
    int           start_cycles = 0;

    eaglesong_msg_loader_if bus();

    eaglesong_msg_loader #(
        .MAX_BYTES          (32),
        .START_PULSE_CYCLES (2),
        .TIMEOUT_CYCLES     (120)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.core_eval_output_ready = stub_ready;
    assign bus.core_output_val        = stub_out;

    always #5 clk = ~clk;

    function automatic logic [255:0] stub_digest(input logic [255:0] v, input logic [6:0] n);
        if (v == HELLO_VAL && n == 7'd14) return HELLO_DIG;
        return ~v ^ {249'd0, n};
    endfunction

    // The stand-in keeps its old ready high until the cycle after the start pulse ends.
    always @(posedge clk) begin
        if (bus.core_start_eval) begin
            stub_armed   <= 1'b1;
            start_cycles <= start_cycles + 1;
        end else if (stub_armed) begin
            stub_armed <= 1'b0;
            stub_ready <= 1'b0;
            stub_cd    <= 5;
        end else if (stub_cd != 0) begin
            stub_cd <= stub_cd - 1;
            if (stub_cd == 1 && !core_dead) begin
                stub_ready <= 1'b1;
                stub_out   <= stub_digest(bus.core_input_val, bus.core_input_length_bytes);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tx();
        int w;
        for (int i = 0; i < tx.size(); i++) begin
            bus.s_byte  = tx[i];
            bus.s_valid = 1'b1;
            bus.s_last  = (i == tx.size() - 1);
            w = 0;
            while (!bus.s_ready && w < 50) begin
                step();
                w++;
            end
            checks++;
            if (bus.s_ready !== 1'b1) begin
                failures++;
                $display("FAIL send_ready byte %0d: s_ready=%b required 1", i, bus.s_ready);
            end
            step();
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.m_valid && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (bus.m_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_result_wait: m_valid=%b required 1 within 400 cycles", name, bus.m_valid);
        end
    endtask

    task automatic take_result(input string name);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_take: m_valid=%b s_ready=%b required 0/1", name, bus.m_valid, bus.s_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0 ||
            bus.m_error !== 1'b0 || bus.core_start_eval !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: s_ready=%b busy=%b m_valid=%b m_error=%b start=%b required 1/0/0/0/0",
                     bus.s_ready, bus.busy, bus.m_valid, bus.m_error, bus.core_start_eval);
        end
        checks++;
        if (bus.core_input_val !== '0 || bus.core_input_length_bytes !== 7'd0 ||
            bus.m_digest !== '0 || bus.m_length !== 7'd0) begin
            failures++;
            $display("FAIL reset_data: val=%h len=%0d digest=%h m_length=%0d required all zero",
                     bus.core_input_val, bus.core_input_length_bytes, bus.m_digest, bus.m_length);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_hello();
        int n;
        tx = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h77,
               8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        send_tx();
        checks++;
        if (bus.core_input_val !== HELLO_VAL || bus.core_input_length_bytes !== 7'd14) begin
            failures++;
            $display("FAIL hello_input: val=%h len=%0d required %h/14",
                     bus.core_input_val, bus.core_input_length_bytes, HELLO_VAL);
        end
        checks++;
        if (bus.s_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL hello_busy: s_ready=%b busy=%b required 0/1", bus.s_ready, bus.busy);
        end
        n = 0;
        while (bus.core_start_eval && n < 20) begin
            n++;
            step();
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL hello_start_pulse: cycles=%0d required 2", n);
        end
        wait_valid("hello");
        checks++;
        if (bus.m_digest !== HELLO_DIG || bus.m_length !== 7'd14 || bus.m_error !== 1'b0) begin
            failures++;
            $display("FAIL hello_digest: digest=%h len=%0d err=%b required %h/14/0",
                     bus.m_digest, bus.m_length, bus.m_error, HELLO_DIG);
        end
        take_result("hello");
    endtask

    task automatic test_back_to_back();
        tx.delete();
        for (int i = 0; i < 32; i++) tx.push_back(8'hFF);
        send_tx();
        checks++;
        if (bus.core_input_val !== {256{1'b1}} || bus.core_input_length_bytes !== 7'd32) begin
            failures++;
            $display("FAIL b2b_full_input: val=%h len=%0d required all-FF/32",
                     bus.core_input_val, bus.core_input_length_bytes);
        end
        wait_valid("b2b_full");
        checks++;
        if (bus.m_digest !== 256'h20 || bus.m_length !== 7'd32 || bus.m_error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full_digest: digest=%h len=%0d err=%b required 20/32/0",
                     bus.m_digest, bus.m_length, bus.m_error);
        end
        take_result("b2b_full");
        tx = '{8'h41};
        send_tx();
        checks++;
        if (bus.core_input_val !== 256'h41 || bus.core_input_length_bytes !== 7'd1) begin
            failures++;
            $display("FAIL b2b_single_input: val=%h len=%0d required 41/1",
                     bus.core_input_val, bus.core_input_length_bytes);
        end
        wait_valid("b2b_single");
        checks++;
        if (bus.m_digest !== ~256'h40 || bus.m_length !== 7'd1 || bus.m_error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_single_digest: digest=%h len=%0d err=%b required %h/1/0",
                     bus.m_digest, bus.m_length, bus.m_error, ~256'h40);
        end
        take_result("b2b_single");
    endtask

    task automatic test_overflow();
        int s0;
        s0 = start_cycles;
        tx.delete();
        for (int i = 0; i < 33; i++) tx.push_back(8'(i + 1));
        send_tx();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_error !== 1'b1 || bus.m_length !== 7'd32) begin
            failures++;
            $display("FAIL overflow_result: m_valid=%b err=%b len=%0d required 1/1/32",
                     bus.m_valid, bus.m_error, bus.m_length);
        end
        step();
        checks++;
        if (start_cycles != s0) begin
            failures++;
            $display("FAIL overflow_no_start: start cycles=%0d required 0", start_cycles - s0);
        end
        take_result("overflow");
    endtask

    task automatic test_timeout();
        int n;
        core_dead = 1'b1;
        tx = '{8'h01, 8'h02, 8'h03};
        send_tx();
        n = 0;
        while (bus.core_start_eval && n < 20) begin
            n++;
            step();
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL timeout_start_pulse: cycles=%0d required 2", n);
        end
        repeat (119) step();
        checks++;
        if (bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: m_valid=%b at 119 cycles required 0", bus.m_valid);
        end
        step();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_error !== 1'b1 || bus.m_digest !== '0 || bus.m_length !== 7'd3) begin
            failures++;
            $display("FAIL timeout_result: m_valid=%b err=%b digest=%h len=%0d required 1/1/0/3",
                     bus.m_valid, bus.m_error, bus.m_digest, bus.m_length);
        end
        take_result("timeout");
        core_dead = 1'b0;
    endtask

    task automatic test_backpressure();
        tx = '{8'h10, 8'h20};
        send_tx();
        wait_valid("bp");
        checks++;
        if (bus.m_digest !== ~256'h2012) begin
            failures++;
            $display("FAIL bp_digest: digest=%h required %h", bus.m_digest, ~256'h2012);
        end
        bus.s_byte  = 8'h55;
        bus.s_valid = 1'b1;
        bus.s_last  = 1'b1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_digest !== ~256'h2012) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: s_ready=%b m_valid=%b digest=%h",
                         i, bus.s_ready, bus.m_valid, bus.m_digest);
            end
            step();
        end
        take_result("bp");
        step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        checks++;
        if (bus.core_input_val !== 256'h55 || bus.core_input_length_bytes !== 7'd1) begin
            failures++;
            $display("FAIL bp_next_input: val=%h len=%0d required 55/1",
                     bus.core_input_val, bus.core_input_length_bytes);
        end
        wait_valid("bp_next");
        checks++;
        if (bus.m_digest !== ~256'h54 || bus.m_length !== 7'd1 || bus.m_error !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_digest: digest=%h len=%0d err=%b required %h/1/0",
                     bus.m_digest, bus.m_length, bus.m_error, ~256'h54);
        end
        take_result("bp_next");
    endtask

    task automatic test_reset_mid_wait();
        tx = '{8'hAA, 8'hBB, 8'hCC};
        send_tx();
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0 ||
            bus.core_start_eval !== 1'b0 || bus.m_error !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ctrl: s_ready=%b busy=%b m_valid=%b start=%b err=%b required 1/0/0/0/0",
                     bus.s_ready, bus.busy, bus.m_valid, bus.core_start_eval, bus.m_error);
        end
        checks++;
        if (bus.core_input_val !== '0 || bus.core_input_length_bytes !== 7'd0 ||
            bus.m_digest !== '0 || bus.m_length !== 7'd0) begin
            failures++;
            $display("FAIL rst_mid_data: val=%h len=%0d digest=%h m_length=%0d required all zero",
                     bus.core_input_val, bus.core_input_length_bytes, bus.m_digest, bus.m_length);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        tx = '{8'h41, 8'h42};
        send_tx();
        checks++;
        if (bus.core_input_val !== 256'h4241 || bus.core_input_length_bytes !== 7'd2) begin
            failures++;
            $display("FAIL rst_next_input: val=%h len=%0d required 4241/2",
                     bus.core_input_val, bus.core_input_length_bytes);
        end
        wait_valid("rst_next");
        checks++;
        if (bus.m_digest !== ~256'h4243 || bus.m_length !== 7'd2 || bus.m_error !== 1'b0) begin
            failures++;
            $display("FAIL rst_next_digest: digest=%h len=%0d err=%b required %h/2/0",
                     bus.m_digest, bus.m_length, bus.m_error, ~256'h4243);
        end
        take_result("rst_next");
    endtask

    initial begin
        bus.s_byte  = 8'h00;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_hello();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/eaglesong_msg_loader.md
Name: eaglesong_msg_loader

Overview:
- Upstream feeder and result collector for eaglesong_digest_top.
- Accepts a message as a byte stream with valid/ready and a last flag, and packs it little-endian into the core's 256-bit input_val / input_length_bytes.
- Issues start_eval, waits for eval_output_ready, captures output_val and presents the digest on a valid/ready result port.
- Sits between the host-side byte source (UART/bus bridge) and the digest core.

Parameters:
- MAX_BYTES, 32, maximum message length accepted; must be 1..32.
- START_PULSE_CYCLES, 2, number of cycles core_start_eval is held high; must be >= 1.
- TIMEOUT_CYCLES, 120, cycles to wait for core_eval_output_ready before flagging an error.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_byte  in  8  message byte.
- s_valid  in  1  s_byte valid.
- s_last  in  1  marks the final byte of the message; qualified by s_valid.
- s_ready  out  1  loader accepts a byte this cycle.
- core_input_val  out  256  packed message; byte k at bits [8k+7:8k].
- core_input_length_bytes  out  7  message length, 1..32.
- core_start_eval  out  1  start pulse to the core.
- core_output_val  in  256  digest from the core.
- core_eval_output_ready  in  1  core result valid.
- m_digest  out  256  captured digest.
- m_length  out  7  length of the message that produced m_digest.
- m_valid  out  1  result available.
- m_ready  in  1  result consumer ready.
- m_error  out  1  result is invalid (overflow or timeout); qualified by m_valid.
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (async assert, sync release): state=LOAD, byte count=0, core_input_val=0, core_input_length_bytes=0, core_start_eval=0, m_digest=0, m_length=0, m_valid=0, m_error=0, s_ready=1, busy=0. Reset mid-operation aborts immediately; the core is simply not restarted.
- State LOAD:
  - s_ready=1.
  - On s_valid&&s_ready, s_byte is written into byte lane [count]; count increments.
  - Lanes above count are cleared at the first byte of each message, so stale bytes never leak into the next message.
  - If the accepted byte has s_last=1: length=count+1 and go to START next cycle.
  - If count would exceed MAX_BYTES: the byte is dropped, an overflow flag is set, and further bytes are consumed and discarded (s_ready stays 1) until s_last. Then go directly to DONE with m_error=1 and m_length=MAX_BYTES; the core is not started.
- State START:
  - s_ready=0; core_start_eval=1 for exactly START_PULSE_CYCLES cycles.
  - core_input_val and core_input_length_bytes stay stable from entry to START until exit from WAIT.
  - Then go to WAIT.
- State WAIT:
  - core_start_eval=0.
  - core_eval_output_ready is ignored during the first cycle of WAIT, because it may still be high from the previous result.
  - From the second cycle on, when it is 1: capture core_output_val into m_digest, set m_length, m_error=0, go to DONE.
  - A timeout counter runs from WAIT entry. At TIMEOUT_CYCLES with no ready: m_digest=0, m_error=1, go to DONE.
- State DONE:
  - m_valid=1; m_digest, m_length and m_error are held stable.
  - On m_valid&&m_ready: m_valid=0 next cycle, count=0, go to LOAD.
  - s_ready=0 throughout; no input is accepted until the result is taken.
- Latency from accepting the last byte to m_valid=1: 1 + START_PULSE_CYCLES + core latency + 1 cycles.
- Simultaneous s_valid with s_last on the first byte gives a legal 1-byte message (length=1).
- A zero-length message cannot occur, because s_last is only sampled with a byte.

Decomposition:
- Package eaglesong_pkg: state enum (LOAD, START, WAIT, DONE), DIGEST_W=256, LEN_W=7, MAX_MSG_BYTES=32.
- One natural sub-module: eaglesong_byte_packer, containing the lane write/clear logic and the byte counter with overflow detect.
- The FSM, pulse/timeout counters and result register stay in the top.

Test Plan:
- "Hello, world!\n" (48 65 6C 6C 6F 2C 20 77 6F 72 6C 64 21 0A, last on 0A) with the real core.
  - Required: core_input_val=256'h0A21646C726F77202C6F6C6C6548, core_input_length_bytes=14, core_start_eval high for 2 cycles.
  - Required: m_digest=256'hD6727D073CE7EC1ECA9F52DBD0E4954B3F4DCB6B0B43C25D6162D141247E8664, m_length=14, m_error=0.
- Back-to-back messages: 32 bytes of 0xFF, then a 1-byte 0x41.
  - Required: the second core_input_val is exactly 256'h41, with no 0xFF residue; length=1.
- Overflow: 33 bytes with last on byte 33.
  - Required: core_start_eval never asserts; m_valid=1, m_error=1, m_length=32.
- Timeout: stub core that never raises ready.
  - Required: m_valid=1 and m_error=1 exactly 120 cycles after WAIT entry; m_digest=0.
- Backpressure: hold m_ready=0 for 10 cycles with bytes pending.
  - Required: s_ready=0 and m_digest stable throughout; after one m_ready cycle, LOAD resumes and s_ready=1.
- Reset mid-WAIT (reset_n low for 1 cycle).
  - Required: all outputs return to reset values asynchronously; the next message processes correctly.
